// File: rtl/uart_pkg.sv
// Shared types and constants for the UART frame sequencer slice.
// Holds the byte width and the FSM state encoding reported on the debug port.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_NEXT = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  localparam logic [2:0] STA_IDLE = 3'd0;
  localparam logic [2:0] STA_SEND = 3'd1;
  localparam logic [2:0] STA_NEXT = 3'd2;
  localparam logic [2:0] STA_GAP  = 3'd3;

  function automatic logic [2:0] to_sta(input state_t s);
    return {1'b0, s};
  endfunction

endpackage

// File: rtl/uart_gap_timer.sv
// Down-counter that times the idle gap between repeated frames.
// load arms it for CYCLES clocks; expire is high on the last of them.
module uart_gap_timer #(
  parameter int unsigned CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'((CYCLES > 0) ? (CYCLES - 1) : 0);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= LOAD_VAL;
    end else if (enable && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign expire = (count_q == '0);

endmodule

// File: rtl/uart_frame_sequencer.sv
// Splits a latched multi-byte word into a byte stream for a byte UART,
// with optional header byte, selectable byte order and timed repetition.
module uart_frame_sequencer
  import uart_pkg::*;
#(
  parameter int unsigned BYTES      = 5,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter bit          HEADER_EN  = 1'b0,
  parameter logic [7:0]  HEADER     = 8'hAA,
  parameter int unsigned GAP_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [BYTE_W*BYTES-1:0] in_data,
  output logic                    in_ready,
  input  logic                    repeat_en,
  output logic                    tx_send,
  output logic [BYTE_W-1:0]       tx_data,
  input  logic                    tx_done,
  output logic                    busy,
  output logic [15:0]             frames_sent,
  output logic [2:0]              sta
);

  localparam int unsigned HDR       = HEADER_EN ? 1 : 0;
  localparam int unsigned FRAME_LEN = BYTES + HDR;
  localparam int unsigned IW        = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);

  state_t                    state_q, state_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [BYTE_W*BYTES-1:0]   word_q, word_d;
  logic [15:0]               frames_q, frames_d;
  logic                      gap_load, gap_en, gap_expire;
  logic [BYTE_W-1:0]         cur_byte;
  int unsigned               pos;

  uart_gap_timer #(
    .CYCLES (GAP_CYCLES)
  ) u_gap_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (gap_load),
    .enable (gap_en),
    .expire (gap_expire)
  );

  // Byte position within the payload excludes the header slot.
  always_comb begin
    cur_byte = '0;
    pos      = 32'(idx_q) - HDR;
    if (HEADER_EN && (idx_q == '0)) begin
      cur_byte = HEADER;
    end else if (MSB_FIRST) begin
      cur_byte = word_q[BYTE_W*(BYTES-1-pos) +: BYTE_W];
    end else begin
      cur_byte = word_q[BYTE_W*pos +: BYTE_W];
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement leaves a value unassigned and infers a latch.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    word_d   = word_q;
    frames_d = frames_q;
    gap_load = 1'b0;
    gap_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          word_d  = in_data;
          idx_d   = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_done) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (idx_q != LAST_IDX) begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_SEND;
        end else begin
          frames_d = frames_q + 16'd1;
          idx_d    = '0;
          if (!repeat_en) begin
            state_d = ST_IDLE;
          end else if (GAP_CYCLES == 0) begin
            state_d = ST_SEND;
          end else begin
            state_d  = ST_GAP;
            gap_load = 1'b1;
          end
        end
      end
      ST_GAP: begin
        gap_en = 1'b1;
        if (!repeat_en) begin
          state_d = ST_IDLE;
        end else if (gap_expire) begin
          state_d = ST_SEND;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      word_q   <= '0;
      frames_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      word_q   <= word_d;
      frames_q <= frames_d;
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign tx_send     = (state_q == ST_SEND);
  assign tx_data     = tx_send ? cur_byte : '0;
  assign frames_sent = frames_q;
  assign sta         = to_sta(state_q);

endmodule

// File: tb/tb_uart_frame_sequencer.sv
// Directed bench: instance a (MSB first, no header, 4-cycle gap) and
// instance b (LSB first, header, zero gap) driven through fixed scenarios.
module tb_uart_frame_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_in_valid, a_repeat_en, a_tx_done, a_in_ready, a_tx_send, a_busy;
  logic [39:0] a_in_data;
  logic [7:0]  a_tx_data;
  logic [15:0] a_frames;
  logic [2:0]  a_sta;
  logic        b_in_valid, b_repeat_en, b_tx_done, b_in_ready, b_tx_send, b_busy;
  logic [39:0] b_in_data;
  logic [7:0]  b_tx_data;
  logic [15:0] b_frames;
  logic [2:0]  b_sta;

  int passed = 0;
  int total  = 0;

  uart_frame_sequencer #(
    .BYTES(5), .MSB_FIRST(1'b1), .HEADER_EN(1'b0), .HEADER(8'hAA), .GAP_CYCLES(4)
  ) u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_data(a_in_data),
    .in_ready(a_in_ready), .repeat_en(a_repeat_en), .tx_send(a_tx_send),
    .tx_data(a_tx_data), .tx_done(a_tx_done), .busy(a_busy),
    .frames_sent(a_frames), .sta(a_sta)
  );

  uart_frame_sequencer #(
    .BYTES(5), .MSB_FIRST(1'b0), .HEADER_EN(1'b1), .HEADER(8'hAA), .GAP_CYCLES(0)
  ) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_data(b_in_data),
    .in_ready(b_in_ready), .repeat_en(b_repeat_en), .tx_send(b_tx_send),
    .tx_data(b_tx_data), .tx_done(b_tx_done), .busy(b_busy),
    .frames_sent(b_frames), .sta(b_sta)
  );

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic send_of(input bit b);
    return b ? b_tx_send : a_tx_send;
  endfunction

  function automatic logic [7:0] data_of(input bit b);
    return b ? b_tx_data : a_tx_data;
  endfunction

  function automatic logic [2:0] sta_of(input bit b);
    return b ? b_sta : a_sta;
  endfunction

  task automatic set_done(input bit b, input logic v);
    if (b) b_tx_done = v;
    else   a_tx_done = v;
  endtask

  task automatic accept(input bit b, input logic [39:0] word);
    if (b) begin b_in_valid = 1'b1; b_in_data = word; end
    else   begin a_in_valid = 1'b1; a_in_data = word; end
    @(negedge clk);
    if (b) b_in_valid = 1'b0;
    else   a_in_valid = 1'b0;
  endtask

  // Waits for tx_send, checks the byte, answers tx_done; returns in NEXT.
  task automatic serve_byte(input bit b, input logic [7:0] exp, input string tag);
    int n = 0;
    while (!send_of(b) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, " send"}, 40'(send_of(b)), 40'(1));
    check({tag, " data"}, 40'(data_of(b)), 40'(exp));
    repeat (2) @(negedge clk);
    check({tag, " hold"}, 40'(data_of(b)), 40'(exp));
    set_done(b, 1'b1);
    @(negedge clk);
    set_done(b, 1'b0);
    check({tag, " next"}, 40'({send_of(b), sta_of(b)}), 40'({1'b0, 3'd2}));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] tie_exp [5];
    logic [7:0] b_exp [6];
    int n;
    int nb;
    tie_exp = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
    b_exp   = '{8'hAA, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};

    rst = 1'b0;
    a_in_valid = 1'b0; a_repeat_en = 1'b0; a_tx_done = 1'b0; a_in_data = '0;
    b_in_valid = 1'b0; b_repeat_en = 1'b0; b_tx_done = 1'b0; b_in_data = '0;
    repeat (2) @(negedge clk);
    check("rst in_ready", 40'(a_in_ready), 40'(1));
    check("rst busy",     40'(a_busy),     40'(0));
    check("rst tx_send",  40'(a_tx_send),  40'(0));
    check("rst tx_data",  40'(a_tx_data),  40'(0));
    check("rst frames",   40'(a_frames),   40'(0));
    check("rst sta",      40'(a_sta),      40'(0));
    check("rst b ready",  40'(b_in_ready), 40'(1));
    rst = 1'b1;
    @(negedge clk);

    // Single frame, MSB first; a second word offered mid-frame must be ignored.
    accept(1'b0, 40'h0102030405);
    check("f1 sta send", 40'(a_sta),      40'(1));
    check("f1 not ready", 40'(a_in_ready), 40'(0));
    check("f1 busy",     40'(a_busy),     40'(1));
    serve_byte(1'b0, 8'h01, "f1 b0");
    a_in_valid = 1'b1;
    a_in_data  = 40'hFFFFFFFFFF;
    for (int i = 1; i < 4; i++) begin
      serve_byte(1'b0, 8'(i + 1), $sformatf("f1 b%0d", i));
      check($sformatf("f1 ready b%0d", i), 40'(a_in_ready), 40'(0));
    end
    a_in_valid = 1'b0;
    serve_byte(1'b0, 8'h05, "f1 b4");
    @(negedge clk);
    check("f1 end sta",    40'(a_sta),      40'(0));
    check("f1 end ready",  40'(a_in_ready), 40'(1));
    check("f1 end frames", 40'(a_frames),   40'(1));

    // Repeat with a 4-cycle gap, three frames, then drop repeat_en in GAP.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    a_repeat_en = 1'b1;
    accept(1'b0, 40'h0102030405);
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 5; i++) begin
        serve_byte(1'b0, 8'(i + 1), $sformatf("rp f%0d b%0d", f, i));
      end
      if (f < 2) begin
        n = 0;
        @(negedge clk);
        while (!a_tx_send && n < 20) begin
          n++;
          @(negedge clk);
        end
        check($sformatf("rp gap f%0d", f), 40'(n), 40'(4));
      end
    end
    @(negedge clk);
    check("rp in gap",  40'(a_sta),    40'(3));
    check("rp frames3", 40'(a_frames), 40'(3));
    @(negedge clk);
    a_repeat_en = 1'b0;
    @(negedge clk);
    check("rp stop sta",    40'(a_sta),    40'(0));
    check("rp stop busy",   40'(a_busy),   40'(0));
    check("rp stop frames", 40'(a_frames), 40'(3));

    // Reset while byte 3 is being sent.
    accept(1'b0, 40'h1122334455);
    serve_byte(1'b0, 8'h11, "mr b0");
    serve_byte(1'b0, 8'h22, "mr b1");
    n = 0;
    while (!a_tx_send && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("mr b2 send", 40'(a_tx_send), 40'(1));
    check("mr b2 data", 40'(a_tx_data), 40'(8'h33));
    rst = 1'b0;
    @(negedge clk);
    check("mr tx_send", 40'(a_tx_send),  40'(0));
    check("mr sta",     40'(a_sta),      40'(0));
    check("mr tx_data", 40'(a_tx_data),  40'(0));
    check("mr frames",  40'(a_frames),   40'(0));
    check("mr ready",   40'(a_in_ready), 40'(1));
    rst = 1'b1;
    @(negedge clk);

    // tx_done tied high: one byte per two clocks, idle again at cycle 11.
    a_tx_done = 1'b1;
    accept(1'b0, 40'hA1B2C3D4E5);
    nb = 0;
    for (int c = 1; c <= 10; c++) begin
      if (a_tx_send) begin
        if (nb < 5) check($sformatf("tie b%0d", nb), 40'(a_tx_data), 40'(tie_exp[nb]));
        nb++;
      end
      @(negedge clk);
    end
    check("tie count",  40'(nb),         40'(5));
    check("tie ready",  40'(a_in_ready), 40'(1));
    check("tie frames", 40'(a_frames),   40'(1));
    a_tx_done = 1'b0;

    // Header, LSB first, zero gap; repeat_en dropped mid-frame finishes the frame.
    b_repeat_en = 1'b1;
    accept(1'b1, 40'h0102030405);
    for (int i = 0; i < 6; i++) begin
      serve_byte(1'b1, b_exp[i], $sformatf("hb f0 b%0d", i));
    end
    @(negedge clk);
    check("hb nogap sta",  40'(b_sta),     40'(1));
    check("hb nogap data", 40'(b_tx_data), 40'(8'hAA));
    check("hb frames1",    40'(b_frames),  40'(1));
    serve_byte(1'b1, b_exp[0], "hb f1 b0");
    b_repeat_en = 1'b0;
    for (int i = 1; i < 6; i++) begin
      serve_byte(1'b1, b_exp[i], $sformatf("hb f1 b%0d", i));
    end
    @(negedge clk);
    check("hb end sta",    40'(b_sta),    40'(0));
    check("hb end frames", 40'(b_frames), 40'(2));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_frame_sequencer.md
UART_FRAME_SEQUENCER -- requirements
Module: uart_frame_sequencer

Interface
REQ-001 SHALL have parameter BYTES, default 5; payload bytes per frame (>=1).
REQ-002 SHALL have parameter MSB_FIRST, default 1; 1 = most significant byte sent first.
REQ-003 SHALL have parameter HEADER_EN, default 0; 1 = HEADER byte prepended to each frame.
REQ-004 SHALL have parameter HEADER, default 8'hAA; header byte value.
REQ-005 SHALL have parameter GAP_CYCLES, default 1000; idle clocks between repeated frames (>=0).
REQ-006 SHALL have port clk, input, 1; sole clock, rising edge.
REQ-007 SHALL have port rst, input, 1; reset, synchronous and active-low.
REQ-008 SHALL have port in_valid, input, 1; new frame word offered.
REQ-009 SHALL have port in_data, input, 8*BYTES; frame payload word.
REQ-010 SHALL have port in_ready, output, 1; sequencer can accept a word.
REQ-011 SHALL have port repeat_en, input, 1; retransmit the latched word continuously.
REQ-012 SHALL have port tx_send, output, 1; byte request to the byte UART transmitter.
REQ-013 SHALL have port tx_data, output, 8; byte presented with tx_send.
REQ-014 SHALL have port tx_done, input, 1; transmitter has finished the current byte.
REQ-015 SHALL have port busy, output, 1; frame in progress or in gap.
REQ-016 SHALL have port frames_sent, output, 16; completed-frame counter.
REQ-017 SHALL have port sta, output, 3; current state encoding, for debug.

Function
REQ-018 SHALL implement states IDLE, SEND, NEXT, GAP, all registered.
REQ-019 In IDLE: in_ready=1, busy=0, tx_send=0.
REQ-020 IDLE exit: in_valid=1 at an edge latches in_data, clears byte index, enters SEND; tx_send rises the cycle after acceptance.
REQ-021 In SEND: tx_send=1, tx_data=selected byte, held stable.
REQ-022 SEND exit: tx_done=1 in a SEND cycle moves to NEXT; otherwise SEND is held indefinitely.
REQ-023 In NEXT: tx_send=0 for exactly one cycle, giving at least one low cycle between bytes and 2 clocks minimum per byte.
REQ-024 Frame length: BYTES+HEADER_EN bytes; index 0 is HEADER when HEADER_EN=1.
REQ-025 Byte order: MSB_FIRST=1 sends in_data[8*BYTES-1 -: 8] first; MSB_FIRST=0 sends [7:0] first.
REQ-026 NEXT on a non-last byte: increment index, go to SEND.
REQ-027 NEXT on the last byte: frames_sent increments, wrapping 16'hFFFF->0; go to GAP if repeat_en=1, else IDLE.
REQ-028 GAP counts GAP_CYCLES clocks, then enters SEND at index 0 with the same latched word.
REQ-029 GAP_CYCLES=0: NEXT goes directly to SEND.
REQ-030 repeat_en=0 in any GAP cycle: go to IDLE next edge.
REQ-031 repeat_en falling during SEND/NEXT: the current frame completes, then IDLE.
REQ-032 in_ready=0 in all states except IDLE; in_valid outside IDLE is ignored and the latched word is unchanged.
REQ-033 tx_done outside SEND is ignored.
REQ-034 tx_done held permanently high: sequencer advances one byte per 2 clocks with no lockup.
REQ-035 busy=1 in SEND, NEXT and GAP.

Reset
REQ-036 rst=0 at an edge SHALL force IDLE, index=0, gap counter=0, frames_sent=0, latched word=0; tx_send=0 and tx_data=0 from the following cycle, including mid-frame.
REQ-037 Reset SHALL take priority over all other inputs.

Structure
REQ-038 Package uart_pkg SHALL hold the state encoding constants and the byte width (8).
REQ-039 Sub-module uart_gap_timer (load, enable, expire) SHALL implement the GAP counter; byte select and FSM stay in the top module.

Verification
REQ-040 BYTES=5, MSB_FIRST=1, in_data=40'h0102030405, tx_done pulses 3 clocks after each tx_send rise -> tx_data sequence 01,02,03,04,05; frames_sent=1; IDLE.
REQ-041 HEADER_EN=1, MSB_FIRST=0, same word -> AA,05,04,03,02,01.
REQ-042 repeat_en=1, GAP_CYCLES=4 -> exactly 4 GAP cycles between the last NEXT and the next tx_send rise; frames_sent=3 after 3 frames; repeat_en=0 in GAP -> IDLE next cycle.
REQ-043 in_valid with in_data=40'hFFFFFFFFFF during frame 1 -> ignored; all bytes of frame 1 match the first word.
REQ-044 rst=0 while tx_send is high on byte 3 -> tx_send=0 and sta=IDLE the next cycle; frames_sent=0.
REQ-045 tx_done tied high -> 5 bytes sent in 10 cycles; in_ready=1 at cycle 11.
